board_move_merge: RTL

- Sequential slide-and-merge engine for the 4x4 2048 board; direct upstream stage of the random-tile inserter.
- On a start request it applies one move (up/down/left/right) to the board, processing one line per clock.
- It returns the new board, a moved flag, the score increment and a win flag.
- Control logic feeds the result to tile insertion only when moved=1.

---
 rtl/board_move_merge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/board_move_merge.sv
// rtl/board_move_merge.sv - sequential 2048 slide-and-merge engine, one board line per clock
module board_move_merge #(
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         dir,
  input  logic [15:0][3:0]   cell_matrix_in,
  output logic               busy,
  output logic               done,
  output logic [15:0][3:0]   cell_matrix_out,
  output logic               moved,
  output logic [SCORE_W-1:0] score_add,
  output logic               win
);

  typedef enum logic [1:0] {IDLE, PROC, FINISH} state_t;

  localparam logic [4:0] WIN_E = WIN_EXP[4:0];

  state_t               state_q;
  logic [15:0][3:0]     orig_q, work_q, work_d;
  logic [1:0]           dir_q, line_q;
  logic [SCORE_W-1:0]   score_q, line_score;
  logic                 win_acc_q, line_win;
  logic                 busy_q, done_q, moved_q, win_q;
  logic [15:0][3:0]     out_q;
  logic [SCORE_W-1:0]   score_add_q;

  logic [3:0][3:0]      idx;
  logic [3:0][3:0]      ln;
  logic [4:0][3:0]      cmp;
  logic [3:0][3:0]      mrg;
  logic [2:0]           k;
  logic                 skip;

  // Line transform: gather the current line lead-to-trail, compact, merge pairs, scatter back.
  always_comb begin
    work_d     = work_q;
    line_score = '0;
    line_win   = 1'b0;
    cmp        = '0;
    mrg        = '0;
    k          = '0;
    skip       = 1'b0;
    for (int p = 0; p < 4; p++) begin
      case (dir_q)
        2'd0:    idx[p] = {2'(p), line_q};
        2'd1:    idx[p] = {2'(3 - p), line_q};
        2'd2:    idx[p] = {line_q, 2'(p)};
        default: idx[p] = {line_q, 2'(3 - p)};
      endcase
      ln[p] = work_q[idx[p]];
    end
    for (int p = 0; p < 4; p++) begin
      if (ln[p] != 4'd0) begin
        cmp[k] = ln[p];
        k      = k + 3'd1;
      end
    end
    k = '0;
    // cmp[4] stays zero so the last element never finds a partner.
    for (int p = 0; p < 4; p++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[p] != 4'd0 && cmp[p] == cmp[p+1] && cmp[p] != 4'd15) begin
        mrg[k[1:0]] = cmp[p] + 4'd1;
        line_score  = line_score + (SCORE_W'(1) << (cmp[p] + 4'd1));
        if ({1'b0, cmp[p] + 4'd1} >= WIN_E) line_win = 1'b1;
        skip = 1'b1;
        k    = k + 3'd1;
      end else if (cmp[p] != 4'd0) begin
        mrg[k[1:0]] = cmp[p];
        k           = k + 3'd1;
      end
    end
    for (int p = 0; p < 4; p++) work_d[idx[p]] = mrg[p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      orig_q      <= '0;
      work_q      <= '0;
      dir_q       <= '0;
      line_q      <= '0;
      score_q     <= '0;
      win_acc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      moved_q     <= 1'b0;
      score_add_q <= '0;
      win_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            orig_q    <= cell_matrix_in;
            work_q    <= cell_matrix_in;
            dir_q     <= dir;
            line_q    <= '0;
            score_q   <= '0;
            win_acc_q <= 1'b0;
            state_q   <= PROC;
          end
        end
        PROC: begin
          busy_q    <= 1'b1;
          work_q    <= work_d;
          score_q   <= score_q + line_score;
          win_acc_q <= win_acc_q | line_win;
          line_q    <= line_q + 2'd1;
          if (line_q == 2'd3) state_q <= FINISH;
        end
        FINISH: begin
          busy_q      <= 1'b1;
          done_q      <= 1'b1;
          out_q       <= work_q;
          moved_q     <= (work_q != orig_q);
          score_add_q <= score_q;
          win_q       <= win_acc_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign cell_matrix_out = out_q;
  assign moved           = moved_q;
  assign score_add       = score_add_q;
  assign win             = win_q;

endmodule
